// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch with one-entry skid buffer and flush redirect
// Optional misaligned-redirect trap enabled by defining IF_MISALIGN_TRAP_EN.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_data,
   input  logic        i_stall,
   input  logic        i_flush,
   input  logic [31:0] i_branch_pc,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc,
   output logic        o_ce,
   output logic        o_misalign
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_SKID, S_DISCARD, S_TRAP} state_t;

   state_t      state, state_d;
   logic [31:0] pc, pc_d;
   logic [31:0] redir, redir_d;
   logic [31:0] instr_d, opc_d;
   logic        ce_d;
   logic [31:0] skid_instr, skid_instr_d;
   logic [31:0] skid_pc, skid_pc_d;
   logic        slot_free;
   logic [31:0] target;
   logic        trap_flush;
   logic        trap_pending;

   assign slot_free = !o_ce || !i_stall;
   assign target    = {i_branch_pc[31:2], 2'b00};

`ifdef IF_MISALIGN_TRAP_EN
   logic misalign, misalign_d;

   assign trap_flush   = i_flush && (i_branch_pc[1:0] != 2'b00);
   assign trap_pending = misalign;
   assign o_misalign   = misalign;

   always_comb begin
      misalign_d = misalign;
      if (trap_flush && (state == S_REQ || state == S_SKID || state == S_DISCARD))
         misalign_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) misalign <= 1'b0;
      else     misalign <= misalign_d;
   end
`else
   logic unused_branch_lsb;

   assign unused_branch_lsb = ^i_branch_pc[1:0];
   assign trap_flush        = 1'b0;
   assign trap_pending      = 1'b0;
   assign o_misalign        = 1'b0;
`endif

   always_comb begin
      state_d      = state;
      pc_d         = pc;
      redir_d      = redir;
      instr_d      = o_instr;
      opc_d        = o_pc;
      ce_d         = o_ce && i_stall;
      skid_instr_d = skid_instr;
      skid_pc_d    = skid_pc;
      o_imem_req   = 1'b0;
      o_imem_addr  = pc;
      case (state)
         S_IDLE: begin
            o_imem_addr = 32'h0;
            state_d     = S_REQ;
         end
         S_REQ: begin
            o_imem_req = 1'b1;
            if (i_flush) begin
               ce_d = 1'b0;
               if (trap_flush) begin
                  state_d = i_imem_ack ? S_TRAP : S_DISCARD;
               end else if (i_imem_ack) begin
                  pc_d = target;
               end else begin
                  redir_d = target;
                  state_d = S_DISCARD;
               end
            end else if (i_imem_ack) begin
               pc_d = pc + 32'd4;
               if (slot_free) begin
                  instr_d = i_imem_data;
                  opc_d   = pc;
                  ce_d    = 1'b1;
               end else begin
                  skid_instr_d = i_imem_data;
                  skid_pc_d    = pc;
                  state_d      = S_SKID;
               end
            end
         end
         S_SKID: begin
            // No request is outstanding here, so a redirect can restart fetch directly.
            if (i_flush) begin
               ce_d         = 1'b0;
               skid_instr_d = 32'h0;
               skid_pc_d    = 32'h0;
               if (trap_flush) begin
                  state_d = S_TRAP;
               end else begin
                  pc_d    = target;
                  state_d = S_REQ;
               end
            end else if (!i_stall) begin
               instr_d = skid_instr;
               opc_d   = skid_pc;
               ce_d    = 1'b1;
               state_d = S_REQ;
            end
         end
         S_DISCARD: begin
            // Old request stays on the bus until acked; its data is dropped.
            o_imem_req = 1'b1;
            if (i_flush) begin
               ce_d = 1'b0;
               if (!trap_flush) redir_d = target;
            end
            if (i_imem_ack) begin
               if (trap_pending || trap_flush) begin
                  state_d = S_TRAP;
               end else begin
                  pc_d    = i_flush ? target : redir;
                  state_d = S_REQ;
               end
            end
         end
         S_TRAP: begin
            ce_d = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc         <= RESET_PC;
         redir      <= RESET_PC;
         o_instr    <= 32'h0;
         o_pc       <= 32'h0;
         o_ce       <= 1'b0;
         skid_instr <= 32'h0;
         skid_pc    <= 32'h0;
      end else begin
         pc         <= pc_d;
         redir      <= redir_d;
         o_instr    <= instr_d;
         o_pc       <= opc_d;
         o_ce       <= ce_d;
         skid_instr <= skid_instr_d;
         skid_pc    <= skid_pc_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed bench for instr_fetch with a fetch-stream reference model
`timescale 1ns/1ps
module tb_instr_fetch;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ack;
   logic [31:0] i_imem_data;
   logic        i_stall;
   logic        i_flush;
   logic [31:0] i_branch_pc;
   logic [31:0] o_instr;
   logic [31:0] o_pc;
   logic        o_ce;
   logic        o_misalign;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
      .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data),
      .i_stall(i_stall), .i_flush(i_flush), .i_branch_pc(i_branch_pc),
      .o_instr(o_instr), .o_pc(o_pc), .o_ce(o_ce), .o_misalign(o_misalign)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   // Reference model: the in-order stream of words decode must see, and the next useful fetch address.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } word_t;

   word_t       exp_q[$];
   word_t       w;
   logic [31:0] exp_next;
   bit          discard_pending;
   bit          exp_trap;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         exp_next        = RESET_PC;
         discard_pending = 1'b0;
         exp_trap        = 1'b0;
      end else begin
         chk1("misalign_flag", o_misalign, exp_trap);
         if (o_imem_req) chk("req_addr_aligned", {30'h0, o_imem_addr[1:0]}, 32'h0);
         if (i_flush && !exp_trap) begin
            exp_q.delete();
            exp_next = {i_branch_pc[31:2], 2'b00};
            if (o_imem_req && !i_imem_ack) discard_pending = 1'b1;
`ifdef IF_MISALIGN_TRAP_EN
            if (i_branch_pc[1:0] != 2'b00) exp_trap = 1'b1;
`endif
         end else begin
            if (o_ce && !i_stall) begin
               if (exp_q.size() == 0) begin
                  chk1("stream_unexpected_word", o_ce, 1'b0);
               end else begin
                  w = exp_q.pop_front();
                  chk("stream_pc", o_pc, w.pc);
                  chk("stream_instr", o_instr, w.instr);
               end
            end
            if (o_imem_req && i_imem_ack) begin
               if (discard_pending) begin
                  discard_pending = 1'b0;
               end else begin
                  chk("req_addr", o_imem_addr, exp_next);
                  exp_q.push_back('{exp_next, i_imem_data});
                  exp_next = exp_next + 32'd4;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   logic [11:0] stall_pat;

   initial begin
      rst = 1'b1; i_imem_ack = 1'b0; i_imem_data = 32'h0;
      i_stall = 1'b0; i_flush = 1'b0; i_branch_pc = 32'h0;
      cyc(); cyc();
      chk1("rst_ce", o_ce, 1'b0);
      chk("rst_instr", o_instr, 32'h0);
      chk("rst_pc", o_pc, 32'h0);
      chk1("rst_req", o_imem_req, 1'b0);
      chk("rst_addr", o_imem_addr, 32'h0);
      chk1("rst_misalign", o_misalign, 1'b0);

      rst = 1'b0;
      chk1("idle_req", o_imem_req, 1'b0);
      cyc();
      chk1("first_req", o_imem_req, 1'b1);
      chk("first_addr", o_imem_addr, RESET_PC);
      cyc();
      chk1("req_held", o_imem_req, 1'b1);
      chk("addr_held", o_imem_addr, 32'h0);
      i_imem_ack = 1'b1; i_imem_data = 32'h0000_0013;
      cyc(); i_imem_ack = 1'b0;
      chk1("w0_ce", o_ce, 1'b1);
      chk("w0_pc", o_pc, 32'h0);
      chk("w0_instr", o_instr, 32'h0000_0013);
      chk("w0_next_addr", o_imem_addr, 32'h4);

      i_stall = 1'b1; i_imem_ack = 1'b1; i_imem_data = 32'h0084_0393;
      cyc(); i_imem_ack = 1'b0;
      chk1("skid_req", o_imem_req, 1'b0);
      chk1("skid_ce", o_ce, 1'b1);
      chk("skid_instr_hold", o_instr, 32'h0000_0013);
      chk("skid_pc_hold", o_pc, 32'h0);
      cyc();
      chk1("skid_req2", o_imem_req, 1'b0);
      chk("skid_instr_hold2", o_instr, 32'h0000_0013);
      i_stall = 1'b0;
      cyc();
      chk1("unskid_ce", o_ce, 1'b1);
      chk("unskid_instr", o_instr, 32'h0084_0393);
      chk("unskid_pc", o_pc, 32'h4);
      chk1("unskid_req", o_imem_req, 1'b1);
      chk("unskid_addr", o_imem_addr, 32'h8);

      i_flush = 1'b1; i_branch_pc = 32'h10;
      cyc(); i_flush = 1'b0;
      chk1("disc_ce", o_ce, 1'b0);
      chk1("disc_req", o_imem_req, 1'b1);
      chk("disc_addr_old", o_imem_addr, 32'h8);
      cyc(); cyc();
      i_imem_ack = 1'b1; i_imem_data = 32'hDEAD_BEEF;
      cyc(); i_imem_ack = 1'b0;
      chk1("disc_drop_ce", o_ce, 1'b0);
      chk("disc_drop_instr", o_instr, 32'h0084_0393);
      chk1("disc_done_req", o_imem_req, 1'b1);
      chk("disc_done_addr", o_imem_addr, 32'h10);

      i_flush = 1'b1; i_branch_pc = 32'h20; i_imem_ack = 1'b1; i_imem_data = 32'hBAD0_BAD0;
      cyc(); i_flush = 1'b0; i_imem_ack = 1'b0;
      chk1("flush_ack_ce", o_ce, 1'b0);
      chk1("flush_ack_req", o_imem_req, 1'b1);
      chk("flush_ack_addr", o_imem_addr, 32'h20);

      stall_pat = 12'b0110_1101_1000;
      for (int i = 0; i < 12; i++) begin
         i_imem_ack  = o_imem_req;
         i_imem_data = word_at(o_imem_addr);
         i_stall     = stall_pat[i];
         cyc();
         if (i == 0) begin
            chk1("stream0_ce", o_ce, 1'b1);
            chk("stream0_pc", o_pc, 32'h20);
            chk("stream0_instr", o_instr, 32'hFFDF_0020);
         end
      end
      i_imem_ack = 1'b0; i_stall = 1'b0;
      cyc(); cyc(); cyc();
      chk1("drained_ce", o_ce, 1'b0);

      i_flush = 1'b1; i_branch_pc = 32'hFFFF_FFFC; i_imem_ack = o_imem_req; i_imem_data = 32'hBAD0_BAD0;
      cyc(); i_flush = 1'b0; i_imem_ack = 1'b0;
      chk("wrap_req_addr", o_imem_addr, 32'hFFFF_FFFC);
      i_imem_ack = 1'b1; i_imem_data = 32'h1111_1111;
      cyc(); i_imem_ack = 1'b0;
      chk1("wrap_ce", o_ce, 1'b1);
      chk("wrap_pc", o_pc, 32'hFFFF_FFFC);
      chk("wrap_instr", o_instr, 32'h1111_1111);
      chk("wrap_next_addr", o_imem_addr, 32'h0);

      i_flush = 1'b1; i_branch_pc = 32'h30;
      cyc();
      i_branch_pc = 32'h40;
      cyc(); i_flush = 1'b0;
      chk("reflush_old_addr", o_imem_addr, 32'h0);
      i_imem_ack = 1'b1; i_imem_data = 32'h2222_2222;
      cyc(); i_imem_ack = 1'b0;
      chk1("reflush_ce", o_ce, 1'b0);
      chk("reflush_addr", o_imem_addr, 32'h40);

      i_flush = 1'b1; i_branch_pc = 32'h12;
      cyc(); i_flush = 1'b0;
      i_imem_ack = 1'b1; i_imem_data = 32'h3333_3333;
      cyc(); i_imem_ack = 1'b0;
      chk1("mis_ce", o_ce, 1'b0);
`ifdef IF_MISALIGN_TRAP_EN
      chk1("mis_flag", o_misalign, 1'b1);
      chk1("mis_req", o_imem_req, 1'b0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();
`else
      chk1("mis_flag", o_misalign, 1'b0);
      chk1("mis_req", o_imem_req, 1'b1);
      chk("mis_addr", o_imem_addr, 32'h10);
`endif

      i_flush = 1'b1; i_branch_pc = 32'h4; i_imem_ack = 1'b1; i_imem_data = 32'hBAD0_BAD0;
      cyc(); i_flush = 1'b0;
      i_imem_data = 32'h4444_4444; i_stall = 1'b1;
      cyc(); i_imem_ack = 1'b0;
      chk1("prerst_ce", o_ce, 1'b1);
      chk("prerst_addr", o_imem_addr, 32'h8);
      #2 rst = 1'b1;
      #1;
      chk1("arst_ce", o_ce, 1'b0);
      chk1("arst_req", o_imem_req, 1'b0);
      chk("arst_addr", o_imem_addr, 32'h0);
      chk("arst_instr", o_instr, 32'h0);
      i_imem_ack = 1'b1; i_imem_data = 32'h6666_6666; i_stall = 1'b0;
      cyc();
      rst = 1'b0;
      cyc(); i_imem_ack = 1'b0;
      chk1("restart_req", o_imem_req, 1'b1);
      chk("restart_addr", o_imem_addr, RESET_PC);
      chk1("restart_ce", o_ce, 1'b0);
      i_imem_ack = 1'b1; i_imem_data = 32'h5555_5555;
      cyc(); i_imem_ack = 1'b0;
      chk1("restart_w_ce", o_ce, 1'b1);
      chk("restart_w_pc", o_pc, 32'h0);
      chk("restart_w_instr", o_instr, 32'h5555_5555);
      chk("restart_next_addr", o_imem_addr, 32'h4);
      cyc(); cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port o_imem_req  output  1  instruction memory request.
REQ-005 SHALL have port o_imem_addr  output  32  request address, word aligned.
REQ-006 SHALL have port i_imem_ack  input  1  memory acknowledge; i_imem_data valid this cycle.
REQ-007 SHALL have port i_imem_data  input  32  fetched instruction word.
REQ-008 SHALL have port i_stall  input  1  decode stall; output word not consumed this cycle.
REQ-009 SHALL have port i_flush  input  1  decode redirect request.
REQ-010 SHALL have port i_branch_pc  input  32  redirect target, sampled when i_flush=1.
REQ-011 SHALL have port o_instr  output  32  instruction to decode.
REQ-012 SHALL have port o_pc  output  32  address of o_instr.
REQ-013 SHALL have port o_ce  output  1  o_instr/o_pc valid; consumed when o_ce=1 and i_stall=0.
REQ-014 SHALL have port o_misalign  output  1  misaligned-redirect trap flag.

Function
REQ-015 SHALL implement FSM states S_IDLE, S_REQ, S_SKID, S_DISCARD, S_TRAP.
REQ-016 S_IDLE: o_imem_req=0; always -> S_REQ next cycle.
REQ-017 S_REQ: o_imem_req=1, o_imem_addr=pc; req and addr held stable until i_imem_ack.
REQ-018 Output slot free when o_ce=0 or i_stall=0.
REQ-019 Ack in S_REQ, slot free, no flush: o_instr<=data, o_pc<=pc, o_ce<=1, pc<=pc+4, stay S_REQ (new req next cycle).
REQ-020 Ack in S_REQ, slot full (o_ce=1, i_stall=1): data/pc -> one-entry skid buffer, pc<=pc+4, -> S_SKID.
REQ-021 S_SKID: o_imem_req=0; when i_stall=0, output<=skid, o_ce stays 1, -> S_REQ.
REQ-022 Consumption without new ack: o_ce<=0 next cycle.
REQ-023 Latency: ack in cycle N -> o_ce=1 with that word in cycle N+1; back-to-back 1 word/cycle with single-cycle ack and no stall.
REQ-024 i_flush has priority over stall, ack and skid: o_ce<=0, skid cleared, pc<=target.
REQ-025 Flush in S_REQ without ack same cycle -> S_DISCARD; S_DISCARD keeps req high at old addr until ack, drops data, then -> S_REQ at target.
REQ-026 Flush with ack same cycle: data dropped, -> S_REQ at target next cycle.
REQ-027 Flush in S_DISCARD: target overwritten by newest i_branch_pc, state unchanged.
REQ-028 pc arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-029 o_misalign=0 and S_TRAP unreachable unless REQ-036 applies.

Reset
REQ-030 rst=1 SHALL asynchronously force: state S_IDLE, pc=RESET_PC, o_ce=0, o_instr=0, o_pc=0, o_imem_req=0, o_imem_addr=0 while in S_IDLE, skid empty, o_misalign=0.
REQ-031 Reset mid-transaction SHALL abandon the outstanding request; any ack during or in the cycle after reset release SHALL be ignored.
REQ-032 First request SHALL be issued in the second cycle after rst deassertion (S_IDLE then S_REQ).

Configuration
REQ-033 SHALL use macro IF_MISALIGN_TRAP_EN.
REQ-034 Without macro: redirect target forced to {i_branch_pc[31:2],2'b00}; o_misalign tied 0.
REQ-035 With macro: flush with i_branch_pc[1:0]!=0 SHALL set o_misalign=1 (sticky until reset), o_ce<=0.
REQ-036 With macro: trap path -> S_TRAP (via S_DISCARD if request outstanding); S_TRAP: o_imem_req=0, flush ignored, exit only on rst.

Verification
REQ-037 Reset, RESET_PC=0, ack 1 cycle after req with 32'h00000013 -> next cycle o_ce=1, o_pc=0, o_instr=32'h00000013; next o_imem_addr=32'h4.
REQ-038 Hold i_stall=1 with o_ce=1, ack 32'h00840393 at addr 4 -> o_imem_req=0, output unchanged; release stall -> o_instr=32'h00840393, o_pc=4 next cycle, then req addr 8.
REQ-039 Req at addr 8 pending, i_flush=1, i_branch_pc=32'h10, ack 3 cycles later with 32'hDEADBEEF -> word never on o_instr; next req addr 32'h10.
REQ-040 i_flush and ack in same cycle, i_branch_pc=32'h20 -> o_ce=0 next cycle, next req addr 32'h20.
REQ-041 i_branch_pc=32'h12 flush: with IF_MISALIGN_TRAP_EN o_misalign=1, no further req; without, next req addr 32'h10, o_misalign=0.
REQ-042 rst pulse while req pending at addr 32'h8 -> o_ce=0 and o_imem_req=0 immediately; fetch restarts at RESET_PC.
